// File: rtl/stoper_ctrl.sv
// Stopwatch controller: button sync/edge detect, IDLE/RUN/PAUSE/LAP FSM,
// ms prescaler, lap capture and display mux.
//
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_start_stop, i_lap,
//   i_clear               debounced button levels (async to i_clk)
//   i_bcd_time[23:0]      live BCD time from the counter
//   o_cnt_en              one-cycle ms advance to the counter
//   o_cnt_clr             one-cycle clear to the counter
//   o_disp_bcd[23:0]      value to display (lap register while in LAP)
//   o_running             high in RUN or LAP
//   o_lap_valid           high in LAP
//   o_lap_cnt[3:0]        laps since clear, saturating at 15
module stoper_ctrl #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_stop,
  input  logic        i_lap,
  input  logic        i_clear,
  input  logic [23:0] i_bcd_time,
  output logic        o_cnt_en,
  output logic        o_cnt_clr,
  output logic [23:0] o_disp_bcd,
  output logic        o_running,
  output logic        o_lap_valid,
  output logic [3:0]  o_lap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  localparam logic [15:0] PMAX = 16'(CLK_PER_MS - 1);

  state_t      state;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  prev;
  logic [2:0]  ev;
  logic        ev_ss;
  logic        ev_lap;
  logic        ev_clr;
  logic        adv;
  logic [15:0] presc;
  logic [23:0] lap_reg;

  // bit order: {clear, lap, start_stop}
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {i_clear, i_lap, i_start_stop};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign ev     = sync2 & ~prev;
  assign ev_ss  = ev[0];
  assign ev_lap = ev[1];
  assign ev_clr = ev[2];

  assign o_running   = (state == RUN) || (state == LAP);
  assign o_lap_valid = (state == LAP);

  // The only way out of RUN/LAP is start_stop; freezing the prescaler
  // on that edge keeps the sub-ms phase intact across a pause and
  // keeps o_cnt_en from firing in the first PAUSE cycle.
  assign adv = o_running && !ev_ss;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      presc     <= '0;
      lap_reg   <= '0;
      o_lap_cnt <= '0;
      o_cnt_en  <= 1'b0;
      o_cnt_clr <= 1'b0;
    end else begin
      o_cnt_en  <= 1'b0;
      o_cnt_clr <= 1'b0;
      if (adv) begin
        presc    <= (presc == PMAX) ? 16'd0 : presc + 16'd1;
        o_cnt_en <= (presc == PMAX);
      end
      unique case (state)
        IDLE: begin
          if (ev_ss) state <= RUN;
        end
        RUN: begin
          if (ev_ss) begin
            state <= PAUSE;
          end else if (ev_lap) begin
            state   <= LAP;
            lap_reg <= i_bcd_time;
            if (o_lap_cnt != 4'd15)
              o_lap_cnt <= o_lap_cnt + 4'd1;
          end
        end
        LAP: begin
          if (ev_ss) state <= PAUSE;
          else if (ev_lap) state <= RUN;
        end
        PAUSE: begin
          if (ev_clr) begin
            state     <= IDLE;
            presc     <= '0;
            o_lap_cnt <= '0;
            o_cnt_clr <= 1'b1;
          end else if (ev_ss) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_disp_bcd = o_lap_valid ? lap_reg : i_bcd_time;

endmodule

// File: tb/tb_stoper_ctrl.sv
// Testbench for stoper_ctrl: directed sequences, a vector table and
// random button traffic checked against a reference model.
module tb_stoper_ctrl;

  localparam int N = 4;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_PAUSE = 2'd2;
  localparam logic [1:0] M_LAP   = 2'd3;

  logic        clk;
  logic        rst;
  logic        ss;
  logic        lp;
  logic        cl;
  logic [23:0] bcd;
  logic        cnt_en;
  logic        cnt_clr;
  logic [23:0] disp;
  logic        running;
  logic        lap_valid;
  logic [3:0]  lap_cnt;

  int n_pass;
  int n_total;
  bit chk_on;

  stoper_ctrl #(.CLK_PER_MS(N)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start_stop (ss),
    .i_lap        (lp),
    .i_clear      (cl),
    .i_bcd_time   (bcd),
    .o_cnt_en     (cnt_en),
    .o_cnt_clr    (cnt_clr),
    .o_disp_bcd   (disp),
    .o_running    (running),
    .o_lap_valid  (lap_valid),
    .o_lap_cnt    (lap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model. hX[0] is the newest sampled button level; an
  // event acts when the level seen two samples back is high and the
  // one before that was low (2-flop sync + edge detect).
  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] presc;
    logic [3:0]  lapcnt;
    logic [23:0] lapreg;
    logic        en;
    logic        clr;
    logic [2:0]  hs;
    logic [2:0]  hl;
    logic [2:0]  hc;
  } mdl_t;

  mdl_t m;

  function automatic logic is_run(logic [1:0] s);
    return (s == M_RUN) || (s == M_LAP);
  endfunction

  function automatic mdl_t step(mdl_t cur, logic s, logic l,
                                logic c, logic [23:0] b);
    mdl_t n;
    logic es;
    logic el;
    logic ec;
    n  = cur;
    es = cur.hs[1] & ~cur.hs[2];
    el = cur.hl[1] & ~cur.hl[2];
    ec = cur.hc[1] & ~cur.hc[2];
    n.en  = 1'b0;
    n.clr = 1'b0;
    case (cur.st)
      M_IDLE: if (es) n.st = M_RUN;
      M_RUN: begin
        if (es) n.st = M_PAUSE;
        else if (el) begin
          n.st     = M_LAP;
          n.lapreg = b;
          n.lapcnt = (cur.lapcnt == 4'd15) ? 4'd15
                                           : cur.lapcnt + 4'd1;
        end
      end
      M_LAP: begin
        if (es) n.st = M_PAUSE;
        else if (el) n.st = M_RUN;
      end
      default: begin
        if (ec) begin
          n.st     = M_IDLE;
          n.presc  = 16'd0;
          n.lapcnt = 4'd0;
          n.clr    = 1'b1;
        end else if (es) n.st = M_RUN;
      end
    endcase
    // time advances only on edges spent entirely in a running state
    if (is_run(cur.st) && is_run(n.st)) begin
      n.en    = (int'(cur.presc) == N - 1);
      n.presc = 16'((int'(cur.presc) + 1) % N);
    end
    n.hs = {cur.hs[1:0], s};
    n.hl = {cur.hl[1:0], l};
    n.hc = {cur.hc[1:0], c};
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else m <= step(m, ss, lp, cl, bcd);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_running", 32'(running), 32'(is_run(m.st)));
      chk("m_lap_valid", 32'(lap_valid), 32'(m.st == M_LAP));
      chk("m_lap_cnt", 32'(lap_cnt), 32'(m.lapcnt));
      chk("m_cnt_en", 32'(cnt_en), 32'(m.en));
      chk("m_cnt_clr", 32'(cnt_clr), 32'(m.clr));
      chk("m_disp", 32'(disp),
          32'((m.st == M_LAP) ? m.lapreg : bcd));
    end
  end

  // all stimulus changes 1 time unit after the falling edge
  task automatic cyc(int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(logic s, logic l, logic c);
    ss = s;
    lp = l;
    cl = c;
    cyc(1);
    ss = 1'b0;
    lp = 1'b0;
    cl = 1'b0;
  endtask

  typedef struct {
    logic s;
    logic l;
    logic c;
    logic run;
    logic lv;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[14];
  int   cnt;
  int   k;
  bit   hit;

  initial begin
    n_pass  = 0;
    n_total = 0;
    chk_on  = 0;
    rst = 1'b1;
    ss  = 1'b0;
    lp  = 1'b0;
    cl  = 1'b0;
    bcd = 24'h012345;

    tbl[0]  = '{0, 1, 0, 0, 0, 4'd0};
    tbl[1]  = '{0, 0, 1, 0, 0, 4'd0};
    tbl[2]  = '{1, 0, 0, 1, 0, 4'd0};
    tbl[3]  = '{0, 0, 1, 1, 0, 4'd0};
    tbl[4]  = '{0, 1, 0, 1, 1, 4'd1};
    tbl[5]  = '{0, 0, 1, 1, 1, 4'd1};
    tbl[6]  = '{0, 1, 0, 1, 0, 4'd1};
    tbl[7]  = '{0, 1, 0, 1, 1, 4'd2};
    tbl[8]  = '{1, 0, 0, 0, 0, 4'd2};
    tbl[9]  = '{0, 1, 0, 0, 0, 4'd2};
    tbl[10] = '{1, 0, 0, 1, 0, 4'd2};
    tbl[11] = '{1, 1, 0, 0, 0, 4'd2};
    tbl[12] = '{1, 1, 1, 0, 0, 4'd0};
    tbl[13] = '{1, 1, 0, 1, 0, 4'd0};

    cyc(3);
    chk("rst_running", 32'(running), 0);
    chk("rst_lap_valid", 32'(lap_valid), 0);
    chk("rst_lap_cnt", 32'(lap_cnt), 0);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_cnt_clr", 32'(cnt_clr), 0);
    rst = 1'b0;
    chk_on = 1;
    cyc(2);

    // start: visible on the 3rd edge, cnt_en every 4 cycles after
    pulse(1, 0, 0);
    cyc(1);
    chk("start_edge2", 32'(running), 0);
    cyc(1);
    chk("start_edge3", 32'(running), 1);
    chk("start_en0", 32'(cnt_en), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("start_en_phase", 32'(cnt_en), 32'(i % 4 == 0));
    end

    // lap freezes display while counting continues
    pulse(0, 1, 0);
    cyc(2);
    chk("lap_valid", 32'(lap_valid), 1);
    chk("lap_cnt1", 32'(lap_cnt), 1);
    chk("lap_disp", 32'(disp), 32'h012345);
    bcd = 24'h059999;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (cnt_en) cnt++;
    end
    chk("lap_frozen", 32'(disp), 32'h012345);
    chk("lap_en_pulses", 32'(cnt), 2);
    pulse(0, 1, 0);
    cyc(2);
    chk("lap_release", 32'(lap_valid), 0);
    chk("lap_release_run", 32'(running), 1);
    chk("lap_live", 32'(disp), 32'h059999);
    chk("lap_cnt_hold", 32'(lap_cnt), 1);

    // pause with prescaler held at 2
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      if (m.presc == 16'd0) hit = 1;
      else cyc(1);
    end
    chk("pause_align", 32'(hit), 1);
    pulse(1, 0, 0);
    cyc(2);
    chk("pause_state", 32'(running), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (cnt_en) cnt++;
    end
    chk("pause_no_en", 32'(cnt), 0);
    pulse(1, 0, 0);
    cyc(2);
    chk("resume_run", 32'(running), 1);
    chk("resume_en0", 32'(cnt_en), 0);
    k = 0;
    hit = 0;
    for (int i = 1; i <= 6 && !hit; i++) begin
      cyc(1);
      if (cnt_en) begin
        hit = 1;
        k = i;
      end
    end
    chk("resume_first_en", 32'(k), 2);

    // clear + start_stop together in PAUSE: clear wins
    pulse(1, 0, 0);
    cyc(3);
    pulse(1, 0, 1);
    cyc(1);
    chk("clr_early", 32'(cnt_clr), 0);
    cyc(1);
    chk("clr_idle", 32'(running), 0);
    chk("clr_pulse", 32'(cnt_clr), 1);
    chk("clr_lap_cnt", 32'(lap_cnt), 0);
    cyc(1);
    chk("clr_one_cycle", 32'(cnt_clr), 0);
    cyc(4);
    chk("clr_no_run", 32'(running), 0);

    // vector table, starting from IDLE with no laps
    foreach (tbl[i]) begin
      pulse(tbl[i].s, tbl[i].l, tbl[i].c);
      cyc(3);
      chk($sformatf("tbl%0d_run", i), 32'(running),
          32'(tbl[i].run));
      chk($sformatf("tbl%0d_lv", i), 32'(lap_valid),
          32'(tbl[i].lv));
      chk($sformatf("tbl%0d_cnt", i), 32'(lap_cnt),
          32'(tbl[i].cnt));
    end

    // clear ignored in RUN, then saturate the lap counter
    pulse(0, 0, 1);
    cyc(3);
    chk("run_clr_ign", 32'(running), 1);
    for (int i = 0; i < 34; i++) begin
      bcd = 24'(i);
      pulse(0, 1, 0);
      cyc(3);
    end
    chk("sat_cnt", 32'(lap_cnt), 15);
    chk("sat_run", 32'(lap_valid), 0);
    bcd = 24'h031415;
    pulse(0, 1, 0);
    cyc(3);
    chk("sat_lap", 32'(lap_valid), 1);
    chk("sat_cnt2", 32'(lap_cnt), 15);
    chk("sat_capture", 32'(disp), 32'h031415);
    bcd = 24'h000777;

    // async reset mid-LAP, start_stop held through release
    #2;
    rst = 1'b1;
    ss  = 1'b1;
    #1;
    chk("arst_running", 32'(running), 0);
    chk("arst_lap_valid", 32'(lap_valid), 0);
    chk("arst_lap_cnt", 32'(lap_cnt), 0);
    chk("arst_cnt_en", 32'(cnt_en), 0);
    chk("arst_cnt_clr", 32'(cnt_clr), 0);
    chk("arst_disp", 32'(disp), 32'h000777);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("held_edge2", 32'(running), 0);
    cyc(1);
    chk("held_event", 32'(running), 1);
    cyc(10);
    chk("held_once", 32'(running), 1);
    ss = 1'b0;
    cyc(3);

    // random traffic; one button level changes per cycle
    for (int i = 0; i < 1500; i++) begin
      k = int'($urandom_range(0, 2));
      case (k)
        0: ss = 1'($urandom_range(0, 1));
        1: lp = 1'($urandom_range(0, 1));
        default: cl = ($urandom_range(0, 3) == 0);
      endcase
      bcd = 24'($urandom);
      cyc(1);
    end
    ss = 1'b0;
    lp = 1'b0;
    cl = 1'b0;
    cyc(4);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stoper_ctrl.md
STOPER_CTRL -- requirements
Module: stoper_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_PER_MS, default 50000, giving i_clk cycles per millisecond tick; legal range 2..65535.
REQ-002 The block SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_start_stop  input  1  debounced start/stop button level, asynchronous to i_clk.
REQ-005 The block SHALL have port i_lap  input  1  debounced lap button level, asynchronous to i_clk.
REQ-006 The block SHALL have port i_clear  input  1  debounced clear button level, asynchronous to i_clk.
REQ-007 The block SHALL have port i_bcd_time  input  24  live BCD time from the stopwatch counter: [23:20] min, [19:12] sec, [11:0] ms.
REQ-008 The block SHALL have port o_cnt_en  output  1  one-cycle millisecond advance enable to the stopwatch counter.
REQ-009 The block SHALL have port o_cnt_clr  output  1  one-cycle synchronous clear to the stopwatch counter.
REQ-010 The block SHALL have port o_disp_bcd  output  24  BCD value to display.
REQ-011 The block SHALL have port o_running  output  1  high in RUN or LAP.
REQ-012 The block SHALL have port o_lap_valid  output  1  high in LAP (display frozen).
REQ-013 The block SHALL have port o_lap_cnt  output  4  laps taken since last clear, saturating.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer then a rising-edge detector; the event is one cycle wide; state changes on the 3rd rising i_clk edge after the input rises.
REQ-015 Level-held buttons SHALL produce exactly one event; a new event requires a low level seen by the synchronizer first.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE, LAP, encoded in a registered state vector.
REQ-017 IDLE: start_stop event -> RUN; lap and clear events ignored.
REQ-018 RUN: start_stop -> PAUSE; lap -> LAP, capturing i_bcd_time into lap register, o_lap_cnt +1; clear ignored.
REQ-019 LAP: lap -> RUN (display released, no new capture, no count change); start_stop -> PAUSE; clear ignored.
REQ-020 PAUSE: start_stop -> RUN; clear -> IDLE with o_cnt_clr high for exactly the following cycle; lap ignored.
REQ-021 Simultaneous events in one cycle SHALL be prioritized clear > start_stop > lap; only the winner acts, others are discarded.
REQ-022 A 16-bit prescaler SHALL count 0..CLK_PER_MS-1 only in RUN and LAP, wrap to 0, and hold its value in PAUSE so sub-ms time is preserved.
REQ-023 o_cnt_en SHALL be registered, high for one cycle in the cycle after the prescaler equals CLK_PER_MS-1 while in RUN or LAP; never high in IDLE or PAUSE.
REQ-024 On the PAUSE->IDLE clear, the prescaler SHALL reset to 0 and o_lap_cnt to 0 in the same edge.
REQ-025 o_disp_bcd SHALL equal the lap register in LAP, otherwise i_bcd_time (combinational pass-through).
REQ-026 o_lap_cnt SHALL saturate at 15; further laps still capture and enter LAP.
REQ-027 o_running and o_lap_valid SHALL be decoded directly from the state register.

Reset
REQ-028 Asserting i_rst SHALL immediately force: state IDLE, prescaler 0, lap register 0, o_lap_cnt 0, o_cnt_en 0, o_cnt_clr 0, synchronizer and edge flops 0.
REQ-029 Reset mid-RUN SHALL not pulse o_cnt_clr; the counter's own reset is responsible for its clear.
REQ-030 A button held high through reset release SHALL generate one event after release (edge detector reset to 0).

Verification (CLK_PER_MS=4)
REQ-031 Reset, pulse start_stop -> o_running high on 3rd edge; o_cnt_en pulses every 4 cycles, first 4 cycles after entering RUN.
REQ-032 In RUN with i_bcd_time=24'h012345, pulse lap -> o_lap_valid=1, o_lap_cnt=1, o_disp_bcd stays 24'h012345 while i_bcd_time changes; o_cnt_en keeps pulsing; second lap -> RUN, display live.
REQ-033 Pause when prescaler=2, hold 20 cycles, resume -> zero o_cnt_en during pause; first pulse after resume 2 cycles later.
REQ-034 In PAUSE, assert clear and start_stop in same cycle -> IDLE, one o_cnt_clr pulse, o_lap_cnt=0, no RUN entry.
REQ-035 Clear in RUN -> ignored; 17 laps -> o_lap_cnt=15; i_rst asserted mid-LAP -> all outputs at reset values without waiting for a clock edge.
